// File: rtl/ifetch_queue_pkg.sv
// Shared opcode constants, next-PC selector and immediate decoders for the fetch unit.
package ifetch_queue_pkg;

    localparam logic [6:0] BOP    = 7'b1100011;
    localparam logic [6:0] JALOP  = 7'b1101111;
    localparam logic [6:0] JALROP = 7'b1100111;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_JAL,
        NPC_HOLD
    } npc_sel_e;

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus: icache/predictor request, redirects, and the issue handshake.
interface ifetch_queue_if #(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_to_icache;
    logic            icache_hit;
    logic [31:0]     icache_inst;
    logic            predict;
    logic            jalr_valid;
    logic [XLEN-1:0] jalr_pc;
    logic            rollback;
    logic [XLEN-1:0] rollback_pc;
    logic            issue_ready;
    logic            issue_valid;
    logic [XLEN-1:0] issue_pc;
    logic [31:0]     issue_inst;
    logic            issue_predict;
    logic [CW-1:0]   q_count;

    modport master (
        output pc_to_icache, issue_valid, issue_pc, issue_inst, issue_predict, q_count,
        input  icache_hit, icache_inst, predict, jalr_valid, jalr_pc,
        input  rollback, rollback_pc, issue_ready
    );

    modport slave (
        input  pc_to_icache, issue_valid, issue_pc, issue_inst, issue_predict, q_count,
        output icache_hit, icache_inst, predict, jalr_valid, jalr_pc,
        output rollback, rollback_pc, issue_ready
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Circular instruction buffer: power-of-two depth, flush clears pointers only.
module ifq_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= din;
    end

    assign dout = mem[head];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: PC generation, JALR stall, rollback, and a queue toward issue.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    ifetch_queue_if.master    bus
);
    localparam int            CW   = $clog2(QDEPTH) + 1;
    localparam int            EW   = XLEN + 33;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [XLEN-1:0] pc;
    logic            stall;
    logic [CW-1:0]   count;
    logic [6:0]      opcode;
    logic            predict_eff;
    logic            do_enq;
    logic            do_deq;
    logic [EW-1:0]   head_entry;
    npc_sel_e        npc_sel;
    logic [XLEN-1:0] next_pc;

    logic signed [XLEN-1:0] imm_b_x;
    logic signed [XLEN-1:0] imm_j_x;

    assign opcode      = bus.icache_inst[6:0];
    assign predict_eff = (opcode == BOP) ? bus.predict : False;
    assign imm_b_x     = XLEN'(imm_b(bus.icache_inst));
    assign imm_j_x     = XLEN'(imm_j(bus.icache_inst));

    // Rollback hides the head so nothing stale is issued in the flush cycle.
    assign bus.issue_valid = (count != '0) && !bus.rollback;
    assign do_deq = bus.issue_valid && bus.issue_ready && rdy;
    assign do_enq = bus.icache_hit && !stall && (count < FULL) && rdy
                    && !bus.rollback && !bus.jalr_valid;

    ifq_fifo #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_enq),
        .pop   (do_deq),
        .flush (rdy && bus.rollback),
        .din   ({pc, bus.icache_inst, predict_eff}),
        .dout  (head_entry),
        .count (count)
    );

    assign {bus.issue_pc, bus.issue_inst, bus.issue_predict} = head_entry;
    assign bus.q_count      = count;
    assign bus.pc_to_icache = pc;

    always_comb begin
        npc_sel = NPC_SEQ;
        case (opcode)
            BOP:     npc_sel = bus.predict ? NPC_BRANCH : NPC_SEQ;
            JALOP:   npc_sel = NPC_JAL;
            JALROP:  npc_sel = NPC_HOLD;
            default: npc_sel = NPC_SEQ;
        endcase
    end

    always_comb begin
        next_pc = pc + XLEN'(4);
        case (npc_sel)
            NPC_BRANCH: next_pc = pc + imm_b_x;
            NPC_JAL:    next_pc = pc + imm_j_x;
            NPC_HOLD:   next_pc = pc;
            default:    next_pc = pc + XLEN'(4);
        endcase
    end

    // JALR is queued, then fetch parks until the ALU supplies the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            stall <= False;
        end else if (rdy) begin
            if (bus.rollback) begin
                pc    <= bus.rollback_pc;
                stall <= False;
            end else if (bus.jalr_valid) begin
                if (stall) begin
                    pc    <= bus.jalr_pc;
                    stall <= False;
                end
            end else if (do_enq) begin
                pc <= next_pc;
                if (npc_sel == NPC_HOLD) stall <= True;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: vector table plus hand sequences for stall, rdy and wrap.
module tb_ifetch_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'hFE00_08E3;
    localparam logic [31:0] JAL  = 32'h1000_006F;
    localparam logic [31:0] JALR = 32'h0000_8067;
    localparam int          N    = 33;

    typedef struct {
        logic        rdy;
        logic        hit;
        logic [31:0] inst;
        logic        pred;
        logic        jv;
        logic [31:0] jpc;
        logic        rb;
        logic [31:0] rbpc;
        logic        ir;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        e_ipred;
        logic [2:0]  e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl [N];

    ifetch_queue_if #(.XLEN(32), .QDEPTH(4)) bus ();

    ifetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic hit, input logic [31:0] inst, input logic pred,
                                input logic jv, input logic [31:0] jpc,
                                input logic rb, input logic [31:0] rbpc, input logic ir,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic [31:0] e_ipc, input logic e_ipred,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.rdy = 1'b1;  v.hit = hit;   v.inst = inst;     v.pred = pred;
        v.jv = jv;     v.jpc = jpc;   v.rb = rb;         v.rbpc = rbpc;  v.ir = ir;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_ipc = e_ipc;
        v.e_ipred = e_ipred; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check pre-edge outputs on the falling edge, then clock.
    task automatic step(input vec_t v, input string name);
        rdy                 = v.rdy;
        bus.icache_hit      = v.hit;
        bus.icache_inst     = v.inst;
        bus.predict         = v.pred;
        bus.jalr_valid      = v.jv;
        bus.jalr_pc         = v.jpc;
        bus.rollback        = v.rb;
        bus.rollback_pc     = v.rbpc;
        bus.issue_ready     = v.ir;
        @(negedge clk);
        chk({name, " pc"},    bus.pc_to_icache, v.e_pc);
        chk({name, " valid"}, 32'(bus.issue_valid), 32'(v.e_valid));
        chk({name, " count"}, 32'(bus.q_count), 32'(v.e_cnt));
        if (v.e_valid) begin
            chk({name, " ipc"},   bus.issue_pc, v.e_ipc);
            chk({name, " ipred"}, 32'(bus.issue_predict), 32'(v.e_ipred));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        //          hit inst  pd jv jpc     rb rbpc    ir  e_pc     ev e_ipc    ep cnt
        tbl[0]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h000,  0, 32'h000, 0, 0);
        tbl[1]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h004,  1, 32'h000, 0, 1);
        tbl[2]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h008,  1, 32'h004, 0, 1);
        tbl[3]  = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h00C,  1, 32'h008, 0, 1);
        tbl[4]  = mk(0, NOP,  0, 0, 32'h0,  1, 32'h0,  1, 32'h00C,  0, 32'h000, 0, 0);
        tbl[5]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h000,  0, 32'h000, 0, 0);
        tbl[6]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h004,  1, 32'h000, 0, 1);
        tbl[7]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h008,  1, 32'h000, 0, 2);
        tbl[8]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h00C,  1, 32'h000, 0, 3);
        tbl[9]  = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h010,  1, 32'h000, 0, 4);
        tbl[10] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h010,  1, 32'h000, 0, 4);
        tbl[11] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h010,  1, 32'h004, 0, 3);
        tbl[12] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h014,  1, 32'h008, 0, 3);
        tbl[13] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h014,  1, 32'h00C, 0, 2);
        tbl[14] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h014,  1, 32'h010, 0, 1);
        tbl[15] = mk(0, NOP,  0, 0, 32'h0,  1, 32'h20, 1, 32'h014,  0, 32'h000, 0, 0);
        tbl[16] = mk(1, BEQ,  1, 0, 32'h0,  0, 32'h0,  0, 32'h020,  0, 32'h000, 0, 0);
        tbl[17] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h010,  1, 32'h020, 1, 1);
        tbl[18] = mk(0, NOP,  0, 0, 32'h0,  1, 32'h20, 1, 32'h010,  0, 32'h000, 0, 0);
        tbl[19] = mk(1, BEQ,  0, 0, 32'h0,  0, 32'h0,  1, 32'h020,  0, 32'h000, 0, 0);
        tbl[20] = mk(1, JAL,  1, 0, 32'h0,  0, 32'h0,  1, 32'h024,  1, 32'h020, 0, 1);
        tbl[21] = mk(0, NOP,  1, 0, 32'h0,  0, 32'h0,  1, 32'h124,  1, 32'h024, 0, 1);
        tbl[22] = mk(0, NOP,  0, 0, 32'h0,  1, 32'h40, 1, 32'h124,  0, 32'h000, 0, 0);
        tbl[23] = mk(1, JALR, 0, 0, 32'h0,  0, 32'h0,  0, 32'h040,  0, 32'h000, 0, 0);
        tbl[24] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h040,  1, 32'h040, 0, 1);
        tbl[25] = mk(1, NOP,  0, 1, 32'h200, 0, 32'h0, 0, 32'h040,  1, 32'h040, 0, 1);
        tbl[26] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h200,  1, 32'h040, 0, 1);
        tbl[27] = mk(0, NOP,  0, 1, 32'h300, 0, 32'h0, 0, 32'h204,  1, 32'h200, 0, 1);
        tbl[28] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h204,  1, 32'h200, 0, 1);
        tbl[29] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h204,  1, 32'h200, 0, 1);
        tbl[30] = mk(1, NOP,  0, 0, 32'h0,  0, 32'h0,  0, 32'h208,  1, 32'h200, 0, 2);
        tbl[31] = mk(1, NOP,  0, 0, 32'h0,  1, 32'h80, 1, 32'h20C,  0, 32'h000, 0, 3);
        tbl[32] = mk(0, NOP,  0, 0, 32'h0,  0, 32'h0,  1, 32'h080,  0, 32'h000, 0, 0);

        rst = 1'b1;
        rdy = 1'b1;
        bus.icache_hit  = 1'b0; bus.icache_inst = NOP; bus.predict     = 1'b0;
        bus.jalr_valid  = 1'b0; bus.jalr_pc     = '0;  bus.rollback    = 1'b0;
        bus.rollback_pc = '0;   bus.issue_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < N; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Fill two entries, then freeze with rdy low while hits and ready keep arriving.
        step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 32'h080, 0, 32'h000, 0, 0), "fill0");
        step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 32'h084, 1, 32'h080, 0, 1), "fill1");
        for (int k = 0; k < 3; k++) begin
            v = mk(1, NOP, 0, 0, 0, 0, 0, 1, 32'h088, 1, 32'h080, 0, 2);
            v.rdy = 1'b0;
            step(v, $sformatf("hold%0d", k));
        end
        step(mk(1, NOP, 0, 0, 0, 0, 0, 1, 32'h088, 1, 32'h080, 0, 2), "resume");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 1, 32'h08C, 1, 32'h084, 0, 2), "drain0");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 1, 32'h08C, 1, 32'h088, 0, 1), "drain1");

        // Ten back-to-back enqueue/dequeue pairs carry the pointers around the ring.
        for (int k = 0; k <= 10; k++) begin
            v = mk((k < 10), NOP, 0, 0, 0, 0, 0, 1,
                   32'h08C + 32'(4 * k), (k > 0), 32'h08C + 32'(4 * (k - 1)), 0,
                   (k > 0) ? 3'd1 : 3'd0);
            step(v, $sformatf("wrap%0d", k));
        end
        step(mk(0, NOP, 0, 0, 0, 0, 0, 1, 32'h0B4, 0, 32'h000, 0, 0), "empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised instruction fetch unit that decouples fetch from issue through a QDEPTH-entry circular instruction queue.
- Each cycle it drives a PC to the icache and enqueues hit instructions tagged with their PC and branch prediction.
- It computes the next PC (predicted-taken branch, JAL, sequential), stalls on JALR until the ALU resolves the target, and flushes on ROB rollback.
- Sits between icache/predictor and the decode/issue stage.

Parameters:
XLEN, 32, address/data width
QDEPTH, 4, instruction queue entries (power of two, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global enable; all state holds when low
pc_to_icache  output  XLEN  current fetch PC (= pc register)
icache_hit  input  1  icache_inst valid for pc_to_icache this cycle
icache_inst  input  32  instruction at pc_to_icache
predict  input  1  predictor taken bit for pc_to_icache (combinational)
jalr_valid  input  1  JALR target resolved
jalr_pc  input  XLEN  resolved JALR target
rollback  input  1  ROB misprediction flush
rollback_pc  input  XLEN  restart PC
issue_ready  input  1  downstream accepts (not ROB/RS/LSB full)
issue_valid  output  1  queue head valid
issue_pc  output  XLEN  head PC
issue_inst  output  32  head instruction
issue_predict  output  1  head prediction bit
q_count  output  $clog2(QDEPTH)+1  occupancy (debug/perf)

Behaviour:
- Reset: pc=RESET_PC, stall=0, head=tail=0, count=0, hence issue_valid=0, q_count=0. Queue storage is not cleared.
- Priority per clock edge: rst > !rdy (hold everything) > rollback > jalr_valid > normal.
- Queue: circular buffer, head/tail pointers $clog2(QDEPTH) bits wrapping modulo QDEPTH, count 0..QDEPTH.
- Outputs from queue:
  - issue_valid = (count!=0) && !rollback (combinational).
  - issue_pc/inst/predict read from entry[head].
- Dequeue when issue_valid && issue_ready && rdy: head++, count--.
- Enqueue condition: icache_hit && !stall && count<QDEPTH && rdy && !rollback && !jalr_valid.
  - Full check uses count before any same-cycle dequeue (no enqueue into a full queue, even with simultaneous dequeue).
  - On enqueue: entry[tail]={pc, icache_inst, predict_eff}, tail++, count++.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - predict_eff = predict if opcode==BOP, else 0.
- Next PC on enqueue, opcode = icache_inst[6:0]:
  - BOP with predict: pc+immB (sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - JALOP: pc+immJ (sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - JALROP: pc unchanged, stall<=1. The JALR itself is enqueued.
  - Otherwise: pc+4.
  - All additions are modulo 2^XLEN.
- No enqueue: pc unchanged.
- rollback: count=0, head=tail=0, pc<=rollback_pc, stall<=0. Any same-cycle fetch and dequeue are discarded.
- jalr_valid with stall=1: pc<=jalr_pc, stall<=0, queue untouched (dequeue still allowed), no enqueue that cycle.
- jalr_valid with stall=0: ignored.
- rollback with jalr_valid: rollback wins.
- Latency:
  - Instruction hit in cycle N with an empty queue is presented (issue_valid=1) in cycle N+1.
  - Redirected PC is visible on pc_to_icache in the cycle after redirect.

Decomposition:
- Shared package: opcode constants BOP=7'b1100011, JALOP=7'b1101111, JALROP=7'b1100111; True/False; immB/immJ extraction functions.
- One sub-module: ifq_fifo, a parametrised circular buffer (XLEN+33-bit entries, push/pop/flush, count, head data).
- PC/stall logic stays in ifetch_queue.

Test Plan:
- Reset, then hits of ADDI at 0,4,8 with issue_ready=1 -> pc_to_icache 0,4,8,0xC; issue_pc 0,4,8 one cycle after each hit; q_count<=1.
- issue_ready=0, continuous hits from 0 (QDEPTH=4) -> q_count reaches 4, pc stops at 0x10, no further enqueue; assert issue_ready -> entries 0,4,8,0xC drain in order, then 0x10 fetched.
- BEQ at 0x20 with imm=-16, predict=1 -> next pc 0x10, issue_predict=1; same with predict=0 -> next pc 0x24; JAL imm=+0x100 at 0x24 -> next pc 0x124.
- JALR at 0x40 -> enqueued, stall, pc held at 0x40 despite hits; jalr_valid with jalr_pc=0x200 -> next cycle pc=0x200, fetch resumes; jalr_valid with no stall -> no effect.
- Queue holding 3 entries, rollback with rollback_pc=0x80 and a simultaneous hit -> issue_valid=0 that cycle, q_count=0 next cycle, pc=0x80, discarded hit never issued.
- rdy=0 for 3 cycles mid-stream with hits -> pc, q_count and head unchanged; resumes identically; wrap-around check: 10 enqueue/dequeue pairs issue in program order.
